// File: rtl/stroke_rasterizer_if.sv
// Event-in / pixel-write-out bundle between the mouse stage, the stroke rasterizer and the frame-buffer port.
interface stroke_rasterizer_if;
  localparam int unsigned CW = 10;
  localparam int unsigned AW = 19;

  logic [CW-1:0] pos_x;
  logic [CW-1:0] pos_y;
  logic          pen_down;
  logic          pen_color;
  logic          in_valid;
  logic          in_ready;
  logic          clear_req;
  logic [AW-1:0] write_addr;
  logic          write_enable;
  logic          write_data;
  logic          busy;

  modport master (
    output pos_x, pos_y, pen_down, pen_color, in_valid, clear_req,
    input  in_ready, write_addr, write_enable, write_data, busy
  );

  modport slave (
    input  pos_x, pos_y, pen_down, pen_color, in_valid, clear_req,
    output in_ready, write_addr, write_enable, write_data, busy
  );
endinterface

// File: rtl/stroke_rasterizer.sv
// Turns pen events into Bresenham pixel writes on the 1-bit frame buffer, plus a full-screen clear sweep.
module stroke_rasterizer #(
  parameter int unsigned H_PIX = 640,
  parameter int unsigned V_PIX = 480
) (
  input logic               clk,
  input logic               rst,
  stroke_rasterizer_if.slave bus
);
  localparam int unsigned CW = 10;
  localparam int unsigned AW = 19;
  localparam int unsigned EW = 12;
  localparam logic [CW-1:0] XMAX = CW'(H_PIX - 1);
  localparam logic [CW-1:0] YMAX = CW'(V_PIX - 1);

  typedef enum logic [1:0] {IDLE, LINE, CLEAR} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        last_x_q, last_x_d, last_y_q, last_y_d;
  logic                 last_valid_q, last_valid_d;
  logic                 clr_pend_q, clr_pend_d;
  logic [CW-1:0]        cx_q, cx_d, cy_q, cy_d, x1_q, x1_d, y1_q, y1_d;
  logic                 sx_q, sx_d, sy_q, sy_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                 color_q, color_d;
  logic                 we_q, we_d, wdata_q, wdata_d;
  logic [AW-1:0]        waddr_q, waddr_d;

  logic [CW-1:0]        px, py, x0, y0, adx, ady;
  logic                 x_neg, y_neg;
  logic signed [EW:0]   e2;
  logic signed [EW-1:0] err_acc;

  // Clamped end point, start point and direction of the next segment.
  assign px    = (bus.pos_x > XMAX) ? XMAX : bus.pos_x;
  assign py    = (bus.pos_y > YMAX) ? YMAX : bus.pos_y;
  assign x0    = last_valid_q ? last_x_q : px;
  assign y0    = last_valid_q ? last_y_q : py;
  assign x_neg = (px < x0);
  assign y_neg = (py < y0);
  assign adx   = x_neg ? (x0 - px) : (px - x0);
  assign ady   = y_neg ? (y0 - py) : (py - y0);

  assign bus.in_ready     = (state_q == IDLE) && !clr_pend_q && !bus.clear_req;
  assign bus.write_addr   = waddr_q;
  assign bus.write_enable = we_q;
  assign bus.write_data   = wdata_q;
  assign bus.busy         = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    last_valid_d = last_valid_q;
    clr_pend_d   = clr_pend_q | bus.clear_req;
    cx_d         = cx_q;
    cy_d         = cy_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    err_d        = err_q;
    color_d      = color_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    e2           = $signed({err_q, 1'b0});
    err_acc      = err_q;

    case (state_q)
      IDLE: begin
        if (clr_pend_q || bus.clear_req) begin
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (bus.in_valid) begin
          if (bus.pen_down) begin
            cx_d         = x0;
            cy_d         = y0;
            x1_d         = px;
            y1_d         = py;
            sx_d         = x_neg;
            sy_d         = y_neg;
            dx_d         = $signed(EW'(adx));
            dy_d         = -$signed(EW'(ady));
            err_d        = $signed(EW'(adx)) - $signed(EW'(ady));
            color_d      = bus.pen_color;
            last_x_d     = px;
            last_y_d     = py;
            last_valid_d = 1'b1;
            state_d      = LINE;
          end else begin
            last_valid_d = 1'b0;
          end
        end
      end

      LINE: begin
        we_d    = 1'b1;
        waddr_d = AW'({cy_q, cx_q});
        wdata_d = color_q;
        if (cx_q == x1_q && cy_q == y1_q) begin
          state_d = IDLE;
        end else begin
          // Both steps are decided from the pre-update error term.
          if (e2 >= (EW+1)'(dy_q)) begin
            err_acc = err_acc + dy_q;
            cx_d    = sx_q ? (cx_q - CW'(1)) : (cx_q + CW'(1));
          end
          if (e2 <= (EW+1)'(dx_q)) begin
            err_acc = err_acc + dx_q;
            cy_d    = sy_q ? (cy_q - CW'(1)) : (cy_q + CW'(1));
          end
          err_d = err_acc;
        end
      end

      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = AW'({cy_q, cx_q});
        wdata_d = 1'b0;
        if (cx_q == XMAX) begin
          cx_d = '0;
          if (cy_q == YMAX) begin
            clr_pend_d   = 1'b0;
            last_valid_d = 1'b0;
            state_d      = IDLE;
          end else begin
            cy_d = cy_q + CW'(1);
          end
        end else begin
          cx_d = cx_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_x_q     <= '0;
      last_y_q     <= '0;
      last_valid_q <= 1'b0;
      clr_pend_q   <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      sx_q         <= 1'b0;
      sy_q         <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      err_q        <= '0;
      color_q      <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      last_valid_q <= last_valid_d;
      clr_pend_q   <= clr_pend_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      err_q        <= err_d;
      color_q      <= color_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end
endmodule
